// File: rtl/mem_responder_if.sv
// Request/response bus between a load/store core and mem_responder.
// master = core side, slave = responder side.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering byte/half/word loads and stores, with
// read-modify-write for sub-word stores. Define MEM_RESP_MISALIGN_TRAP_EN to trap misaligned/reserved accesses.
module mem_responder #(
  parameter int MEM_WORDS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t        state_reg, state_next;
  logic [AW+1:0] addr_reg;
  logic          we_reg;
  logic [1:0]    size_reg;
  logic          unsigned_reg;
  logic [31:0]   wdata_reg;
  logic          err_reg;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   rd_data_reg;

  logic          accept;
  logic          req_err;
  logic [1:0]    req_size_eff;
  logic [AW-1:0] word_idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   wr_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign accept   = bus.req_valid && (state_reg == IDLE);
  assign word_idx = addr_reg[AW+1:2];

  // Reserved size behaves as a word; the trap build flags it before it is used.
  always_comb begin
    req_size_eff = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    req_err      = 1'b0;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (bus.req_we && (req_size_eff == 2'b10)) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = bus.rsp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else if (accept) begin
      addr_reg     <= bus.req_addr[AW+1:0];
      we_reg       <= bus.req_we;
      size_reg     <= req_size_eff;
      unsigned_reg <= bus.req_unsigned;
      wdata_reg    <= bus.req_wdata;
      err_reg      <= req_err;
    end
  end

  // Array has no reset; an async reset forces IDLE so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (state_reg == READ) begin
      rd_data_reg <= mem[word_idx];
    end
    if (state_reg == WRITE) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_comb begin
    case (size_reg)
      2'b00: begin
        be        = 4'b0001 << addr_reg[1:0];
        wdata_rep = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be        = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_reg[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_reg;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : rd_data_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rd_byte = rd_data_reg[{addr_reg[1:0], 3'b000} +: 8];
    rd_half = addr_reg[1] ? rd_data_reg[31:16] : rd_data_reg[15:0];
    case (size_reg)
      2'b00:   load_data = {{24{~unsigned_reg & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~unsigned_reg & rd_half[15]}}, rd_half};
      default: load_data = rd_data_reg;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == IDLE);
    bus.rsp_valid = (state_reg == RESP);
    bus.rsp_err   = (state_reg == RESP) && err_reg;
    bus.rsp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? load_data : 32'h0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: byte-level memory model, per-cycle
// response compare, literal pins on the model, latency/handshake/reset checks.
module tb_mem_responder;
  localparam int MEM_WORDS = 1024;
  localparam int BYTES     = 4 * MEM_WORDS;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if bus ();

  mem_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mb [BYTES];
  logic [32:0] exp_q [$];

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", what, got, exp);
    end
  endtask

  // Architectural view: memory is a little-endian byte array, accesses are aligned down.
  function automatic void model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err, output int lat);
    int n;
    int base;
    logic [31:0] v;
    rd  = 32'h0;
    err = 1'b0;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    if (sz == 2'b11 || (a % n) != 0) begin
      err = 1'b1;
      lat = 1;
      return;
    end
`endif
    base = int'(a % BYTES);
    base = base - (base % n);
    if (we) begin
      for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v |= {24'h0, mb[base+i]} << (8*i);
      if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
      rd  = v;
      lat = 2;
    end
  endfunction

  always @(negedge clk) begin
    if (reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      end else begin
        check("rsp_rdata", bus.rsp_rdata, exp_q[0][31:0]);
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_q[0][32]});
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic do_req(input string name, input logic [31:0] addr, input logic we,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                        input logic [31:0] lit_rdata, input logic lit_err, input int hold);
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    int          n;
    bus.req_addr     = addr;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    check({name, "_req_ready_idle"}, {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    model(addr, we, sz, uns, wd, m_rd, m_err, m_lat);
    check({name, "_model_rdata"}, m_rd, lit_rdata);
    check({name, "_model_err"}, {31'h0, m_err}, {31'h0, lit_err});
    exp_q.push_back({m_err, m_rd});
    #1;
    bus.req_valid = 1'b0;
    check({name, "_req_ready_busy"}, {31'h0, bus.req_ready}, 32'h0);
    n = 1;
    while (!bus.rsp_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, m_lat);
    if (!bus.rsp_valid) begin
      exp_q.delete();
      return;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      check({name, "_hold_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
    end
    $display("txn %s addr=%h we=%0d size=%0d rdata=%h err=%0d lat=%0d",
             name, addr, we, sz, bus.rsp_rdata, bus.rsp_err, n);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({name, "_valid_drop"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({name, "_req_ready_back"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;
    reset            = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    do_req("sw_100",    32'h100,  1, 2'b10, 0, 32'hDEAD_BEEF, 32'h0,         0, 0);
    do_req("lw_100",    32'h100,  0, 2'b10, 0, 32'h0,         32'hDEAD_BEEF, 0, 0);
    do_req("sb_101",    32'h101,  1, 2'b00, 0, 32'hAAAA_AA12, 32'h0,         0, 0);
    do_req("lw_100b",   32'h100,  0, 2'b10, 0, 32'h0,         32'hDEAD_12EF, 0, 0);
    do_req("lb_103",    32'h103,  0, 2'b00, 0, 32'h0,         32'hFFFF_FFDE, 0, 0);
    do_req("lbu_103",   32'h103,  0, 2'b00, 1, 32'h0,         32'h0000_00DE, 0, 0);
    do_req("lh_102",    32'h102,  0, 2'b01, 0, 32'h0,         32'hFFFF_DEAD, 0, 0);
    do_req("lhu_102",   32'h102,  0, 2'b01, 1, 32'h0,         32'h0000_DEAD, 0, 0);
    do_req("lbu_101",   32'h101,  0, 2'b00, 1, 32'h0,         32'h0000_0012, 0, 0);
    do_req("lb_100",    32'h100,  0, 2'b00, 0, 32'h0,         32'hFFFF_FFEF, 0, 0);
    do_req("sh_100",    32'h100,  1, 2'b01, 0, 32'h5555_8001, 32'h0,         0, 0);
    do_req("lh_100",    32'h100,  0, 2'b01, 0, 32'h0,         32'hFFFF_8001, 0, 0);
    do_req("lhu_100",   32'h100,  0, 2'b01, 1, 32'h0,         32'h0000_8001, 0, 0);
    do_req("lw_1100",   32'h1100, 0, 2'b10, 0, 32'h0,         32'hDEAD_8001, 0, 0);
    do_req("sw_top",    32'hFFFF_FFFC, 1, 2'b10, 0, 32'h0BAD_F00D, 32'h0,    0, 0);
    do_req("lw_ffc",    32'hFFC,  0, 2'b10, 0, 32'h0,         32'h0BAD_F00D, 0, 0);
    do_req("sb_fff",    32'hFFF,  1, 2'b00, 0, 32'h0000_0080, 32'h0,         0, 0);
    do_req("lw_ffc_b",  32'hFFC,  0, 2'b10, 0, 32'h0,         32'h80AD_F00D, 0, 0);
    do_req("lb_fff",    32'hFFF,  0, 2'b00, 0, 32'h0,         32'hFFFF_FF80, 0, 0);
    do_req("lw_hold",   32'h100,  0, 2'b10, 0, 32'h0,         32'hDEAD_8001, 0, 5);

    // Reset during WRITE of a word store must leave the old word in place.
    do_req("sw_200",    32'h200,  1, 2'b10, 0, 32'h1111_1111, 32'h0,         0, 0);
    bus.req_addr  = 32'h200;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_wdata = 32'h0000_0055;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("abort_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    do_req("lw_200",    32'h200,  0, 2'b10, 0, 32'h0,         32'h1111_1111, 0, 0);

`ifdef MEM_RESP_MISALIGN_TRAP_EN
    do_req("sw_102",    32'h102,  1, 2'b10, 0, 32'hCAFE_F00D, 32'h0,         1, 0);
    do_req("lw_100_c",  32'h100,  0, 2'b10, 0, 32'h0,         32'hDEAD_8001, 0, 0);
    do_req("lh_101",    32'h101,  0, 2'b01, 0, 32'h0,         32'h0,         1, 0);
    do_req("lrsv_100",  32'h100,  0, 2'b11, 0, 32'h0,         32'h0,         1, 0);
    do_req("lw_103",    32'h103,  0, 2'b10, 0, 32'h0,         32'h0,         1, 2);
    do_req("sh_103",    32'h103,  1, 2'b01, 0, 32'h0000_7777, 32'h0,         1, 0);
    do_req("lw_100_d",  32'h100,  0, 2'b10, 0, 32'h0,         32'hDEAD_8001, 0, 0);
`else
    do_req("sw_102",    32'h102,  1, 2'b10, 0, 32'hCAFE_F00D, 32'h0,         0, 0);
    do_req("lw_100_c",  32'h100,  0, 2'b10, 0, 32'h0,         32'hCAFE_F00D, 0, 0);
    do_req("lh_101",    32'h101,  0, 2'b01, 0, 32'h0,         32'hFFFF_F00D, 0, 0);
    do_req("lrsv_103",  32'h103,  0, 2'b11, 0, 32'h0,         32'hCAFE_F00D, 0, 0);
    do_req("srsv_200",  32'h200,  1, 2'b11, 0, 32'h2222_3333, 32'h0,         0, 0);
    do_req("lw_200_b",  32'h200,  0, 2'b10, 0, 32'h0,         32'h2222_3333, 0, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024; number of 32-bit words in the internal array (power of two).
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 Port req_valid  input  1  core presents a load/store request.
REQ-005 Port req_ready  output  1  responder can accept a request.
REQ-006 Port req_addr  input  32  byte address.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 Port req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
REQ-010 Port req_wdata  input  32  store data; the byte/half is taken from the low bits.
REQ-011 Port rsp_valid  output  1  response available.
REQ-012 Port rsp_ready  input  1  core accepts the response.
REQ-013 Port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 Port rsp_err  output  1  request was rejected (see Configuration).

Function
REQ-015 The FSM SHALL use states IDLE, READ, WRITE and RESP; req_ready = 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge with req_valid=1 and req_ready=1; addr, we, size, unsigned and wdata SHALL be registered at acceptance.
REQ-017 The word index SHALL be addr[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*MEM_WORDS.
REQ-018 Load: IDLE->READ->RESP; rsp_valid SHALL rise 2 cycles after acceptance.
REQ-019 Word store: IDLE->WRITE->RESP; the array is written at the edge that leaves WRITE; rsp_valid SHALL rise 2 cycles after acceptance.
REQ-020 Byte/half store: IDLE->READ->WRITE->RESP (read-modify-write); only the addressed lane(s) change; rsp_valid SHALL rise 3 cycles after acceptance.
REQ-021 Lane select: byte lane = addr[1:0]; half lane = addr[1] (bits 15:0 or 31:16); little-endian.
REQ-022 Load extension SHALL follow req_unsigned: byte/half zero- or sign-extended to 32 bits; word returned unchanged.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; on that edge the FSM returns to IDLE and rsp_valid drops.
REQ-024 req_ready SHALL first reassert the cycle after the response handshake; no request is accepted in the same cycle as a response handshake.
REQ-025 rsp_rdata SHALL be 0 for stores.

Reset
REQ-026 While reset=0, state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, immediately and without waiting for clk.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Reset asserted in READ or WRITE SHALL abort the request with no array write and no response.

Configuration
REQ-029 With MEM_RESP_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) or req_size=11 SHALL skip READ/WRITE and enter RESP with rsp_err=1 and rsp_rdata=0. rsp_valid rises 1 cycle after acceptance, and the array is unchanged.
REQ-030 Without MEM_RESP_MISALIGN_TRAP_EN, addr[0] is ignored for half, addr[1:0] for word, req_size=11 is treated as word, and rsp_err is constant 0.

Verification
REQ-031 Word store 0xDEADBEEF at 0x100, then word load at 0x100 -> rdata 0xDEADBEEF; rsp_valid 2 cycles after each acceptance.
REQ-032 After REQ-031, byte store 0x12 at 0x101, then load word 0x100 -> 0xDEAD12EF. Also: lb at 0x103 -> 0xFFFFFFDE; lbu at 0x103 -> 0x000000DE; store rsp at 3 cycles.
REQ-033 lh at 0x102 -> 0xFFFFDEAD; lhu at 0x102 -> 0x0000DEAD.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; then rsp_ready=1 -> IDLE, req_ready=1 the next cycle.
REQ-035 Assert reset during WRITE of a word store 0x55 to 0x200 -> outputs at reset values immediately; load at 0x200 afterwards returns the prior contents.
REQ-036 MEM_RESP_MISALIGN_TRAP_EN defined: word store at 0x102 -> rsp_err=1 after 1 cycle, memory unchanged. Undefined: the same store writes word 0x100, rsp_err=0.
